trng_entropy_buffer: RTL and testbench
======================================

TRNG_ENTROPY_BUFFER -- requirements
Module: trng_entropy_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: entropy word width, 8..32.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO depth in words, power of 2, at least 2.
REQ-003 SHALL have parameter RCT_CUTOFF, default 4: number of identical consecutive samples that trips the health test, at least 2.
REQ-004 SHALL have parameter LW, default $clog2(DEPTH)+1: level width.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- iClk  in  1: clock.
- iRst  in  1: synchronous active-high reset.
REQ-006 SHALL have these control ports.
- iEn  in  1: collection enable.
- oSrc_req  out  1: request to the entropy source.
- iSrc_valid  in  1: source sample strobe.
- iSrc_data  in  WIDTH: source sample.
REQ-007 SHALL have these read-side ports.
- oData  out  WIDTH: FIFO head word.
- oValid  out  1: head word valid.
- iPop  in  1: consume head word.
- oLevel  out  LW: current FIFO occupancy.
REQ-008 SHALL have these threshold and interrupt ports.
- iThresh  in  LW: interrupt level threshold; 0 disables it.
- oIrq  out  1: sticky interrupt.
- iIrq_clr  in  1: clear oIrq.
REQ-009 SHALL have these health and status ports.
- oHealth_fail  out  1: health-test failure flag.
- iFail_clr  in  1: acknowledge failure.
- oDrop_cnt  out  8: dropped-sample count.
- oState  out  2: FSM state.

Function
REQ-010 SHALL implement FSM states IDLE=0, FILL=1, FULL=2, FAIL=3, encoded on oState.
REQ-011 SHALL move IDLE->FILL when iEn=1 and level<DEPTH, and IDLE->FULL when iEn=1 and level=DEPTH.
REQ-012 SHALL move FILL->FULL when level becomes DEPTH, and FULL->FILL when level drops below DEPTH.
REQ-013 SHALL move FILL or FULL to IDLE when iEn=0, with FIFO contents retained and still poppable.
REQ-014 SHALL assert oSrc_req combinationally only in FILL.
REQ-015 SHALL accept a sample only when iSrc_valid=1 and state is FILL or FULL; in any other state the sample is ignored, including by the health test.
REQ-016 SHALL push an accepted sample when level<DEPTH, or when level=DEPTH and a pop occurs in the same cycle.
REQ-017 SHALL otherwise drop the sample and increment oDrop_cnt, saturating at 255.
REQ-018 SHALL define a pop as iPop=1 while oValid=1; iPop while empty has no effect.
REQ-019 SHALL present oData first-word-fall-through: oValid=(level!=0), and oData is the oldest word.
REQ-020 SHALL make a word pushed into an empty FIFO at edge N visible on oData/oValid after edge N.
REQ-021 SHALL keep oLevel equal to pushes minus pops; a simultaneous push and pop leaves the level unchanged.
REQ-022 SHALL wrap FIFO pointers modulo DEPTH.
REQ-023 SHALL run a repetition-count health test on every accepted sample, including dropped ones.
- Equal to the previous accepted sample: run count increments.
- Otherwise: run count resets to 1.
- First accepted sample after reset or a FAIL exit: run count = 1.
REQ-024 SHALL, when the run count reaches RCT_CUTOFF, enter FAIL on the next edge.
- The tripping sample is not pushed.
- The FIFO is flushed (level=0).
- oHealth_fail=1.
REQ-025 SHALL, in FAIL, ignore iPop, keep oValid=0, and exit to IDLE only on iFail_clr=1.
- Exit clears oHealth_fail and the run count.
- iFail_clr outside FAIL has no effect.
REQ-026 SHALL set oIrq on the edge where a push changes the level from iThresh-1 to iThresh (iThresh!=0), and on FAIL entry.
REQ-027 SHALL clear oIrq on iIrq_clr=1; if set and clear coincide, set wins.
REQ-028 SHALL give iFail_clr priority over iEn: FAIL always exits to IDLE, and re-evaluates iEn the next cycle.

Reset
REQ-029 SHALL, on iRst=1 at an edge, set the following regardless of other inputs, including mid-FAIL or with the FIFO full.
- State IDLE, FIFO empty, run count 0.
- oValid=0, oLevel=0, oData=0, oIrq=0, oHealth_fail=0, oDrop_cnt=0, oSrc_req=0.

Verification
REQ-030 SHALL check fill and drain with DEPTH=8, iEn=1, 8 distinct samples, then 8 pops.
- oLevel runs 1..8, state FULL, oSrc_req=0.
- Pops return the words in order, then oValid=0 and state FILL.
REQ-031 SHALL check overflow: a 9th sample at level 8 with no pop -> dropped, oDrop_cnt=1; the same with a concurrent pop -> pushed, oLevel stays 8.
REQ-032 SHALL check the health trip with RCT_CUTOFF=4, samples A,5,5,5,5.
- oHealth_fail=1 and oIrq=1 after the 4th 5.
- oLevel=0, state FAIL.
- iFail_clr -> IDLE.
REQ-033 SHALL check the threshold: iThresh=3, push 3 words -> oIrq rises on the 3rd push; iIrq_clr on the same cycle as a re-crossing -> oIrq stays 1.
REQ-034 SHALL check iEn=0 with 5 words stored: state IDLE, oSrc_req=0, samples ignored, 5 pops succeed.
REQ-035 SHALL check iRst=1 with FIFO full and oIrq=1: next cycle all outputs match REQ-029.

Source files
------------

// File: rtl/trng_entropy_buffer.sv
// TRNG entropy buffer: health-tested sample collector feeding a FWFT FIFO.
// Ports: iClk/iRst clock and sync reset; iEn/oSrc_req/iSrc_valid/iSrc_data
// source side; oData/oValid/iPop/oLevel read side; iThresh/oIrq/iIrq_clr
// level interrupt; oHealth_fail/iFail_clr/oDrop_cnt/oState status.
module trng_entropy_buffer #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 8,
    parameter int RCT_CUTOFF = 4,
    parameter int LW         = $clog2(DEPTH) + 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    output logic             oSrc_req,
    input  logic             iSrc_valid,
    input  logic [WIDTH-1:0] iSrc_data,
    output logic [WIDTH-1:0] oData,
    output logic             oValid,
    input  logic             iPop,
    output logic [LW-1:0]    oLevel,
    input  logic [LW-1:0]    iThresh,
    output logic             oIrq,
    input  logic             iIrq_clr,
    output logic             oHealth_fail,
    input  logic             iFail_clr,
    output logic [7:0]       oDrop_cnt,
    output logic [1:0]       oState
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = $clog2(RCT_CUTOFF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2,
        FAIL = 2'd3
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic [WIDTH-1:0] last_q;
    logic [RW-1:0]    rc_q;
    logic [RW-1:0]    rc_d;
    logic             irq_q;
    logic             hfail_q;
    logic [7:0]       drop_q;

    logic accept;
    logic pop;
    logic full;
    logic trip;
    logic push;
    logic drop;
    logic thr_hit;
    logic irq_d;

    always_comb begin
        accept = iSrc_valid && (state_q == FILL || state_q == FULL);
        pop    = iPop && (level_q != '0) && (state_q != FAIL);
        full   = (level_q == LW'(DEPTH));

        // Run count restarts at 1 on the first sample after reset/FAIL
        // (rc_q == 0) or whenever the sample differs from the last one.
        if (rc_q != '0 && iSrc_data == last_q) begin
            rc_d = rc_q + RW'(1);
        end else begin
            rc_d = RW'(1);
        end

        trip = accept && (rc_d == RW'(RCT_CUTOFF));
        // A full FIFO still takes a sample if a pop frees a slot this cycle.
        push = accept && !trip && (!full || pop);
        drop = accept && !trip && full && !pop;

        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        thr_hit = push && !pop && (iThresh != '0)
                  && ((level_q + LW'(1)) == iThresh);
        // Set beats clear when both happen in one cycle.
        if (thr_hit) begin
            irq_d = 1'b1;
        end else if (iIrq_clr) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Storage has no reset; validity is tracked by level_q.
    always_ff @(posedge iClk) begin
        if (push) begin
            mem_q[wptr_q] <= iSrc_data;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            last_q  <= '0;
            rc_q    <= '0;
            irq_q   <= 1'b0;
            hfail_q <= 1'b0;
            drop_q  <= '0;
        end else if (trip) begin
            state_q <= FAIL;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            last_q  <= iSrc_data;
            rc_q    <= rc_d;
            irq_q   <= 1'b1;
            hfail_q <= 1'b1;
        end else if (state_q == FAIL) begin
            irq_q <= iIrq_clr ? 1'b0 : irq_q;
            if (iFail_clr) begin
                state_q <= IDLE;
                hfail_q <= 1'b0;
                rc_q    <= '0;
            end
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            level_q <= level_d;
            if (accept) begin
                last_q <= iSrc_data;
                rc_q   <= rc_d;
            end
            if (drop && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
            irq_q <= irq_d;
            if (!iEn) begin
                state_q <= IDLE;
            end else if (level_d == LW'(DEPTH)) begin
                state_q <= FULL;
            end else begin
                state_q <= FILL;
            end
        end
    end

    assign oSrc_req     = (state_q == FILL);
    assign oValid       = (level_q != '0);
    assign oData        = oValid ? mem_q[rptr_q] : '0;
    assign oLevel       = level_q;
    assign oIrq         = irq_q;
    assign oHealth_fail = hfail_q;
    assign oDrop_cnt    = drop_q;
    assign oState       = state_q;

endmodule

// File: tb/tb_trng_entropy_buffer.sv
// Bench for trng_entropy_buffer: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_trng_entropy_buffer;

    localparam int W   = 32;
    localparam int D   = 8;
    localparam int CUT = 4;
    localparam int LW  = 4;

    logic          iClk = 1'b0;
    logic          iRst;
    logic          iEn;
    logic          oSrc_req;
    logic          iSrc_valid;
    logic [W-1:0]  iSrc_data;
    logic [W-1:0]  oData;
    logic          oValid;
    logic          iPop;
    logic [LW-1:0] oLevel;
    logic [LW-1:0] iThresh;
    logic          oIrq;
    logic          iIrq_clr;
    logic          oHealth_fail;
    logic          iFail_clr;
    logic [7:0]    oDrop_cnt;
    logic [1:0]    oState;

    trng_entropy_buffer #(
        .WIDTH(W), .DEPTH(D), .RCT_CUTOFF(CUT), .LW(LW)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .oSrc_req(oSrc_req),
        .iSrc_valid(iSrc_valid), .iSrc_data(iSrc_data),
        .oData(oData), .oValid(oValid), .iPop(iPop), .oLevel(oLevel),
        .iThresh(iThresh), .oIrq(oIrq), .iIrq_clr(iIrq_clr),
        .oHealth_fail(oHealth_fail), .iFail_clr(iFail_clr),
        .oDrop_cnt(oDrop_cnt), .oState(oState)
    );

    always #5 iClk = ~iClk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a word queue plus a few scalars.
    logic [W-1:0] m_q[$];
    int           m_st;
    int           m_rc;
    logic [W-1:0] m_last;
    int           m_drops;
    bit           m_irq;
    bit           m_hf;

    task automatic model_step();
        bit acc;
        bit popv;
        bit pushed;
        int lvl0;
        if (iRst) begin
            m_q.delete();
            m_st = 0; m_rc = 0; m_last = '0;
            m_drops = 0; m_irq = 0; m_hf = 0;
            return;
        end
        acc  = iSrc_valid && (m_st == 1 || m_st == 2);
        popv = iPop && m_q.size() != 0 && m_st != 3;
        if (acc) begin
            m_rc   = (m_rc != 0 && iSrc_data == m_last) ? m_rc + 1 : 1;
            m_last = iSrc_data;
            if (m_rc >= CUT) begin
                m_q.delete();
                m_st = 3; m_hf = 1; m_irq = 1;
                return;
            end
        end
        if (m_st == 3) begin
            if (iIrq_clr) m_irq = 0;
            if (iFail_clr) begin
                m_st = 0; m_hf = 0; m_rc = 0;
            end
            return;
        end
        lvl0   = m_q.size();
        pushed = 0;
        if (popv) void'(m_q.pop_front());
        if (acc) begin
            if (lvl0 < D || popv) begin
                m_q.push_back(iSrc_data);
                pushed = 1;
            end else if (m_drops < 255) begin
                m_drops++;
            end
        end
        if (pushed && !popv && iThresh != 0 && lvl0 + 1 == int'(iThresh))
            m_irq = 1;
        else if (iIrq_clr)
            m_irq = 0;
        if (!iEn) m_st = 0;
        else m_st = (m_q.size() == D) ? 2 : 1;
    endtask

    task automatic check_all();
        logic [W-1:0] hd;
        hd = (m_q.size() != 0) ? m_q[0] : '0;
        chk("level", 32'(oLevel), 32'(m_q.size()));
        chk("valid", 32'(oValid), 32'(m_q.size() != 0));
        chk("data", oData, hd);
        chk("state", 32'(oState), 32'(m_st));
        chk("src_req", 32'(oSrc_req), 32'(m_st == 1));
        chk("irq", 32'(oIrq), 32'(m_irq));
        chk("hfail", 32'(oHealth_fail), 32'(m_hf));
        chk("drops", 32'(oDrop_cnt), 32'(m_drops));
    endtask

    task automatic step();
        model_step();
        @(posedge iClk);
        #1;
        check_all();
    endtask

    task automatic quiet();
        iRst = 0; iSrc_valid = 0; iPop = 0;
        iIrq_clr = 0; iFail_clr = 0;
    endtask

    task automatic do_reset();
        quiet();
        iRst = 1; iEn = 0; iThresh = '0;
        step();
        iRst = 0;
    endtask

    logic [W-1:0] seq = 32'hA000_0000;

    task automatic push1(input bit with_pop);
        quiet();
        seq = seq + 1;
        iSrc_valid = 1; iSrc_data = seq; iPop = with_pop;
        step();
        quiet();
    endtask

    task automatic pop1();
        quiet();
        iPop = 1;
        step();
        quiet();
    endtask

    task automatic sample(input logic [W-1:0] v);
        quiet();
        iSrc_valid = 1; iSrc_data = v;
        step();
        quiet();
    endtask

    initial begin
        quiet();
        iEn = 0; iThresh = '0; iSrc_data = '0;
        #2;
        do_reset();
        chk("rst_level", 32'(oLevel), 0);
        chk("rst_state", 32'(oState), 0);

        // Fill and drain
        iEn = 1; step();
        for (int i = 0; i < D; i++) begin
            push1(0);
            chk("fill_level", 32'(oLevel), 32'(i + 1));
        end
        chk("full_state", 32'(oState), 2);
        chk("full_req", 32'(oSrc_req), 0);

        // Overflow: drop, then push with concurrent pop
        push1(0);
        chk("ovf_drop", 32'(oDrop_cnt), 1);
        push1(1);
        chk("ovf_level", 32'(oLevel), 8);
        for (int i = 0; i < D; i++) pop1();
        chk("drain_valid", 32'(oValid), 0);
        chk("drain_state", 32'(oState), 1);

        // Health trip
        do_reset();
        iEn = 1; step();
        sample(32'hA);
        for (int i = 0; i < CUT; i++) sample(32'h5);
        chk("rct_hf", 32'(oHealth_fail), 1);
        chk("rct_irq", 32'(oIrq), 1);
        chk("rct_state", 32'(oState), 3);
        pop1();
        iFail_clr = 1; step(); quiet();
        chk("rct_exit", 32'(oState), 0);

        // Threshold interrupt and set-over-clear
        do_reset();
        iEn = 1; iThresh = 3; step();
        for (int i = 0; i < 3; i++) push1(0);
        chk("thr_irq", 32'(oIrq), 1);
        iIrq_clr = 1; step(); quiet();
        chk("thr_clr", 32'(oIrq), 0);
        pop1();
        quiet(); seq = seq + 1;
        iSrc_valid = 1; iSrc_data = seq; iIrq_clr = 1;
        step(); quiet();
        chk("thr_setwins", 32'(oIrq), 1);

        // Disable with 5 words stored
        do_reset();
        iEn = 1; step();
        for (int i = 0; i < 5; i++) push1(0);
        iEn = 0; step();
        chk("dis_state", 32'(oState), 0);
        chk("dis_req", 32'(oSrc_req), 0);
        push1(0);
        chk("dis_ignore", 32'(oLevel), 5);
        for (int i = 0; i < 5; i++) pop1();
        chk("dis_empty", 32'(oValid), 0);

        // Reset while full with irq set
        iEn = 1; iThresh = 8; step();
        for (int i = 0; i < D; i++) push1(0);
        chk("pre_rst_irq", 32'(oIrq), 1);
        iSrc_valid = 1; iPop = 1; iRst = 1; step(); quiet();
        chk("rst2_data", oData, 0);
        chk("rst2_state", 32'(oState), 0);

        // Random traffic with a narrow sample alphabet to provoke trips
        for (int c = 0; c < 3000; c++) begin
            iRst       = ($urandom_range(0, 199) == 0);
            iEn        = ($urandom_range(0, 9) != 0);
            iSrc_valid = $urandom_range(0, 1);
            iSrc_data  = ($urandom_range(0, 1) != 0) ?
                         W'($urandom_range(0, 2)) : W'($urandom);
            iPop       = ($urandom_range(0, 2) == 0);
            iIrq_clr   = ($urandom_range(0, 7) == 0);
            iFail_clr  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0)
                iThresh = LW'($urandom_range(0, D));
            step();
        end
        quiet();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
